multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle main control FSM for the MIPS datapath; next generation of the single-cycle opcode decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, one datapath step per cycle.
- Adds variable-latency memory handshake, optional jump support, memory-wait timeout, illegal-opcode trap and a retired-instruction counter.
- Sits between the instruction register (supplies OpCode) and the shared-memory multi-cycle datapath.

Parameters:
- HAS_JUMP, 1: 1 decodes J (000010); 0 treats J as illegal.
- MEM_TIMEOUT, 0: maximum MemReady wait cycles per access; 0 means wait forever.
- TMO_W, 8: width of the wait counter; MEM_TIMEOUT must be < 2^TMO_W.
- CNT_W, 32: width of InstrCount.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- OpCode  input  6  IR[31:26]; valid and stable from DECODE until the next FETCH.
- MemReady  input  1  memory completes the current access this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  conditional PC load; datapath qualifies it with Zero, or with !Zero when BranchNE=1.
- BranchNE  output  1  inverts the branch condition.
- IorD  output  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  instruction register load.
- MemtoReg  output  1  write-back data select: 0=ALUOut, 1=MDR.
- RegDest  output  1  destination register select: 0=rt, 1=rd.
- RegWrite  output  1  register file write enable.
- ALUSrcA  output  1  ALU input A select: 0=PC, 1=A.
- ALUSrcB  output  2  ALU input B select: 00=B, 01=4, 10=ext imm, 11=sext imm<<2.
- ZeroExt  output  1  immediate extension: 1=zero-extend (ANDI/ORI).
- ALUOp  output  3  000=add, 001=sub, 010=use funct, 011=and, 100=or.
- PCSource  output  2  PC source: 00=ALU, 01=ALUOut, 10=jump target.
- Retire  output  1  instruction-complete pulse.
- IllegalOp  output  1  undecoded-opcode pulse.
- MemTimeout  output  1  memory-wait-expired pulse.
- InstrCount  output  CNT_W  retired-instruction count.
- State  output  4  current state encoding (debug).

Behaviour:
- clk is the only clock; rst is synchronous, active-high.
- Registered state; outputs are decoded from state (Moore). IRWrite, PCWrite in FETCH and the transitions out of wait states are qualified by MemReady (Mealy).
- Any output not listed for a state is 0.
- Reset, including mid-instruction: next state FETCH, InstrCount=0, wait counter=0. While rst=1, all control outputs and pulse outputs are forced to 0.

States:
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00.
  - If MemReady=1: IRWrite=1, PCWrite=1, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=add (branch target into ALUOut). Next state by OpCode:
  - 000000 -> EXEC_R
  - 001000, 001100, 001101 -> EXEC_I
  - 100011, 101011 -> MEM_ADDR
  - 000100, 000101 -> BRANCH
  - 000010 -> JUMP if HAS_JUMP=1
  - anything else -> ILLEGAL
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=010, then WB_R.
- WB_R: RegWrite=1, RegDest=1, MemtoReg=0, Retire=1, then FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, then WB_I.
  - ADDI: ALUOp=add, ZeroExt=0.
  - ANDI: ALUOp=and, ZeroExt=1.
  - ORI: ALUOp=or, ZeroExt=1.
- WB_I: RegWrite=1, RegDest=0, MemtoReg=0, Retire=1, then FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=add. Next state MEM_RD for LW, MEM_WR for SW.
- MEM_RD: MemRead=1, IorD=1. Wait for MemReady, then MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDest=0, Retire=1, then FETCH.
- MEM_WR: MemWrite=1, IorD=1. On MemReady: Retire=1, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCWriteCond=1, PCSource=01, BranchNE=(OpCode==000101), Retire=1, then FETCH.
- JUMP: PCWrite=1, PCSource=10, Retire=1, then FETCH.
- ILLEGAL: IllegalOp=1 for one cycle, then FETCH. Not retired; PC is already advanced.

Memory wait counter (FETCH, MEM_RD, MEM_WR):
- Cleared on entry to a wait state; increments each cycle MemReady=0.
- If MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT with MemReady still 0: MemTimeout=1 for one cycle, request outputs are dropped, next state FETCH, no Retire.
- MemReady=1 in the same cycle the counter reaches MEM_TIMEOUT: the access completes; no timeout.

Counting and latency:
- InstrCount increments on the clock edge ending every cycle with Retire=1.
- InstrCount wraps from 2^CNT_W-1 to 0 without flagging.
- Latency with MemReady always 1: R/I-type 4 cycles, LW 5, SW 4, BEQ/BNE 3, J 3.

Test Plan:
- rst=1 for 2 cycles mid-LW (in MEM_RD) -> all outputs 0 during reset; first cycle after release State=FETCH, MemRead=1, InstrCount=0.
- ADD (OpCode 000000), MemReady tied 1 -> states FETCH, DECODE, EXEC_R, WB_R; RegWrite=1, RegDest=1 in cycle 4; InstrCount 0 -> 1.
- LW with MemReady low 3 cycles in MEM_RD, MEM_TIMEOUT=0 -> MemRead=1, IorD=1 held 4 cycles; MEM_WB has MemtoReg=1; total 8 cycles; one Retire.
- BNE (000101) -> BRANCH asserts PCWriteCond=1, BranchNE=1, ALUOp=001, PCSource=01; BEQ gives BranchNE=0.
- ORI -> EXEC_I has ZeroExt=1, ALUOp=100; WB_I has MemtoReg=0. OpCode 111111 -> IllegalOp pulse, InstrCount unchanged, back to FETCH.
- MEM_TIMEOUT=4, MemReady held 0 in FETCH -> MemTimeout pulse in 4th wait cycle, next FETCH restarts. HAS_JUMP=0 with OpCode 000010 -> IllegalOp=1.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS main control FSM with memory handshake, timeout, trap and retire counter
module multicycle_control #(
    parameter int HAS_JUMP    = 1,
    parameter int MEM_TIMEOUT = 0,
    parameter int TMO_W       = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       OpCode,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             BranchNE,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDest,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             ZeroExt,
    output logic [2:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             Retire,
    output logic             IllegalOp,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] InstrCount,
    output logic [3:0]       State
);
    // Encoding follows the order the states are sequenced in; FETCH is 0 so the debug bus idles at 0.
    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR,
        MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, ILLEGAL
    } stateT;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    stateT state, nextState;
    logic [TMO_W-1:0] waitCnt;
    logic [CNT_W-1:0] count;
    logic waitState, timeout;

    // Wait tracking and next-state selection; a timeout always falls back to FETCH.
    always_comb begin
        waitState = state inside {FETCH, MEM_RD, MEM_WR};
        timeout = (MEM_TIMEOUT != 0) && waitState && !MemReady && waitCnt == TMO_LAST;
        case (state)
            FETCH:    nextState = MemReady ? DECODE : FETCH;
            DECODE:   nextState = (OpCode == 6'b000000) ? EXEC_R :
                                  (OpCode inside {6'b001000, 6'b001100, 6'b001101}) ? EXEC_I :
                                  (OpCode inside {6'b100011, 6'b101011}) ? MEM_ADDR :
                                  (OpCode inside {6'b000100, 6'b000101}) ? BRANCH :
                                  (OpCode == 6'b000010 && HAS_JUMP != 0) ? JUMP : ILLEGAL;
            EXEC_R:   nextState = WB_R;
            EXEC_I:   nextState = WB_I;
            MEM_ADDR: nextState = (OpCode == 6'b100011) ? MEM_RD : MEM_WR;
            MEM_RD:   nextState = MemReady ? MEM_WB : timeout ? FETCH : MEM_RD;
            MEM_WR:   nextState = (MemReady || timeout) ? FETCH : MEM_WR;
            default:  nextState = FETCH;
        endcase
    end

    // Control decode from state, with memory-qualified strobes; everything held low during reset.
    always_comb begin
        PCWrite = 1'b0;
        PCWriteCond = 1'b0;
        BranchNE = 1'b0;
        IorD = 1'b0;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        IRWrite = 1'b0;
        MemtoReg = 1'b0;
        RegDest = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA = 1'b0;
        ALUSrcB = 2'b00;
        ZeroExt = 1'b0;
        ALUOp = 3'b000;
        PCSource = 2'b00;
        Retire = 1'b0;
        IllegalOp = 1'b0;
        MemTimeout = 1'b0;
        InstrCount = rst ? '0 : count;
        State = rst ? 4'd0 : state;
        if (!rst) begin
            case (state)
                FETCH: begin
                    MemRead = !timeout;
                    ALUSrcB = 2'b01;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                    MemTimeout = timeout;
                end
                DECODE: ALUSrcB = 2'b11;
                EXEC_R: begin
                    ALUSrcA = 1'b1;
                    ALUOp = 3'b010;
                end
                WB_R: begin
                    RegWrite = 1'b1;
                    RegDest = 1'b1;
                    Retire = 1'b1;
                end
                EXEC_I: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUOp = (OpCode == 6'b001100) ? 3'b011 : (OpCode == 6'b001101) ? 3'b100 : 3'b000;
                    ZeroExt = OpCode != 6'b001000;
                end
                WB_I: begin
                    RegWrite = 1'b1;
                    Retire = 1'b1;
                end
                MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                MEM_RD: begin
                    MemRead = !timeout;
                    IorD = 1'b1;
                    MemTimeout = timeout;
                end
                MEM_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                    Retire = 1'b1;
                end
                MEM_WR: begin
                    MemWrite = !timeout;
                    IorD = 1'b1;
                    Retire = MemReady;
                    MemTimeout = timeout;
                end
                BRANCH: begin
                    ALUSrcA = 1'b1;
                    ALUOp = 3'b001;
                    PCWriteCond = 1'b1;
                    PCSource = 2'b01;
                    BranchNE = OpCode == 6'b000101;
                    Retire = 1'b1;
                end
                JUMP: begin
                    PCWrite = 1'b1;
                    PCSource = 2'b10;
                    Retire = 1'b1;
                end
                ILLEGAL: IllegalOp = 1'b1;
                default: ;
            endcase
        end
    end

    // State, wait counter (cleared whenever not stalling) and wrapping retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            waitCnt <= '0;
            count <= '0;
        end else begin
            state <= nextState;
            waitCnt <= (waitState && !MemReady && !timeout) ? waitCnt + 1'b1 : '0;
            count <= count + CNT_W'(Retire);
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized instruction streams checked cycle by cycle against a phase-level model
module tb_multicycle_control;
    typedef struct packed {
        logic pcWrite, pcWriteCond, branchNE, iorD, memRead, memWrite, irWrite;
        logic memtoReg, regDest, regWrite, aluSrcA;
        logic [1:0] aluSrcB;
        logic zeroExt;
        logic [2:0] aluOp;
        logic [1:0] pcSource;
        logic retire, illegalOp, memTimeout;
    } ctlT;

    localparam logic [3:0] S_FETCH = 0, S_DECODE = 1, S_EXR = 2, S_WBR = 3, S_EXI = 4, S_WBI = 5,
                           S_MADDR = 6, S_RD = 7, S_MWB = 8, S_WR = 9, S_BR = 10, S_J = 11, S_ILL = 12;

    logic clk = 0, rstA = 1, rstB = 1, memReady = 0;
    logic [5:0] opCode = 0;
    wire [21:0] obsA, obsB;
    wire [3:0] stA, stB;
    wire [31:0] cntA;
    wire [2:0] cntB;
    int tests = 0, fails = 0;
    bit sel = 0;
    int memTimeout = 0;
    int hasJump = 1;
    logic [31:0] expCount = 0;

    always #5 clk = ~clk;

    multicycle_control #(.HAS_JUMP(1), .MEM_TIMEOUT(0)) dutA (
        .clk(clk), .rst(rstA), .OpCode(opCode), .MemReady(memReady),
        .PCWrite(obsA[21]), .PCWriteCond(obsA[20]), .BranchNE(obsA[19]), .IorD(obsA[18]),
        .MemRead(obsA[17]), .MemWrite(obsA[16]), .IRWrite(obsA[15]), .MemtoReg(obsA[14]),
        .RegDest(obsA[13]), .RegWrite(obsA[12]), .ALUSrcA(obsA[11]), .ALUSrcB(obsA[10:9]),
        .ZeroExt(obsA[8]), .ALUOp(obsA[7:5]), .PCSource(obsA[4:3]), .Retire(obsA[2]),
        .IllegalOp(obsA[1]), .MemTimeout(obsA[0]), .InstrCount(cntA), .State(stA)
    );

    multicycle_control #(.HAS_JUMP(0), .MEM_TIMEOUT(4), .CNT_W(3)) dutB (
        .clk(clk), .rst(rstB), .OpCode(opCode), .MemReady(memReady),
        .PCWrite(obsB[21]), .PCWriteCond(obsB[20]), .BranchNE(obsB[19]), .IorD(obsB[18]),
        .MemRead(obsB[17]), .MemWrite(obsB[16]), .IRWrite(obsB[15]), .MemtoReg(obsB[14]),
        .RegDest(obsB[13]), .RegWrite(obsB[12]), .ALUSrcA(obsB[11]), .ALUSrcB(obsB[10:9]),
        .ZeroExt(obsB[8]), .ALUOp(obsB[7:5]), .PCSource(obsB[4:3]), .Retire(obsB[2]),
        .IllegalOp(obsB[1]), .MemTimeout(obsB[0]), .InstrCount(cntB), .State(stB)
    );

    task automatic cyc(input logic [5:0] op, input logic rdy, input ctlT e, input logic [3:0] st);
        ctlT oe;
        logic [3:0] os;
        logic [31:0] oc;
        opCode = op;
        memReady = rdy;
        @(negedge clk);
        oe = sel ? ctlT'(obsB) : ctlT'(obsA);
        os = sel ? stB : stA;
        oc = sel ? {29'd0, cntB} : cntA;
        tests++;
        assert (oe === e) else begin fails++; $error("FAIL ctl st=%0d obs=%h exp=%h", st, oe, e); end
        tests++;
        assert (os === st) else begin fails++; $error("FAIL state obs=%0d exp=%0d", os, st); end
        tests++;
        assert (oc === expCount) else begin fails++; $error("FAIL count st=%0d obs=%0d exp=%0d", st, oc, expCount); end
        if (e.retire) expCount = (expCount + 1) & (sel ? 32'h7 : 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
    endtask

    task automatic memWait(input logic [5:0] op, input logic [3:0] st, input int w, output bit done);
        ctlT e;
        bit rdy, tmo;
        done = 1;
        for (int i = 0; i <= w; i++) begin
            rdy = i >= w;
            tmo = memTimeout != 0 && !rdy && i == memTimeout - 1;
            e = '0;
            e.memRead = st != S_WR && !tmo;
            e.memWrite = st == S_WR && !tmo;
            e.iorD = st != S_FETCH;
            e.aluSrcB = st == S_FETCH ? 2'b01 : 2'b00;
            e.irWrite = st == S_FETCH && rdy;
            e.pcWrite = st == S_FETCH && rdy;
            e.retire = st == S_WR && rdy;
            e.memTimeout = tmo;
            cyc(st == S_FETCH ? 6'($urandom) : op, rdy, e, st);
            if (tmo) begin
                done = 0;
                return;
            end
        end
    endtask

    task automatic runInstr(input logic [5:0] op, input int fw, input int mw);
        ctlT e;
        bit ok;
        memWait(op, S_FETCH, fw, ok);
        if (!ok) return;
        e = '0; e.aluSrcB = 2'b11;
        cyc(op, 1'($urandom), e, S_DECODE);
        if (op == 6'd0) begin
            e = '0; e.aluSrcA = 1; e.aluOp = 3'b010;
            cyc(op, 1'($urandom), e, S_EXR);
            e = '0; e.regWrite = 1; e.regDest = 1; e.retire = 1;
            cyc(op, 1'($urandom), e, S_WBR);
        end else if (op inside {6'd8, 6'd12, 6'd13}) begin
            e = '0; e.aluSrcA = 1; e.aluSrcB = 2'b10; e.zeroExt = op != 6'd8;
            e.aluOp = op == 6'd8 ? 3'b000 : op == 6'd12 ? 3'b011 : 3'b100;
            cyc(op, 1'($urandom), e, S_EXI);
            e = '0; e.regWrite = 1; e.retire = 1;
            cyc(op, 1'($urandom), e, S_WBI);
        end else if (op inside {6'd35, 6'd43}) begin
            e = '0; e.aluSrcA = 1; e.aluSrcB = 2'b10;
            cyc(op, 1'($urandom), e, S_MADDR);
            memWait(op, op == 6'd35 ? S_RD : S_WR, mw, ok);
            if (ok && op == 6'd35) begin
                e = '0; e.regWrite = 1; e.memtoReg = 1; e.retire = 1;
                cyc(op, 1'($urandom), e, S_MWB);
            end
        end else if (op inside {6'd4, 6'd5}) begin
            e = '0; e.aluSrcA = 1; e.aluOp = 3'b001; e.pcWriteCond = 1; e.pcSource = 2'b01;
            e.branchNE = op == 6'd5; e.retire = 1;
            cyc(op, 1'($urandom), e, S_BR);
        end else if (op == 6'd2 && hasJump != 0) begin
            e = '0; e.pcWrite = 1; e.pcSource = 2'b10; e.retire = 1;
            cyc(op, 1'($urandom), e, S_J);
        end else begin
            e = '0; e.illegalOp = 1;
            cyc(op, 1'($urandom), e, S_ILL);
        end
    endtask

    function automatic logic [5:0] pickOp();
        logic [5:0] ops[10] = '{6'd0, 6'd8, 6'd12, 6'd13, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd63};
        int k = $urandom_range(10);
        return k == 10 ? 6'($urandom) : ops[k];
    endfunction

    initial begin
        ctlT e;
        bit ok;
        #1;
        cyc(6'd0, 1'b0, '0, S_FETCH);
        cyc(6'd0, 1'b1, '0, S_FETCH);
        rstA = 0;
        runInstr(6'd0, 0, 0);
        runInstr(6'd35, 0, 3);
        runInstr(6'd5, 0, 0);
        runInstr(6'd4, 0, 0);
        runInstr(6'd13, 0, 0);
        runInstr(6'd12, 1, 0);
        runInstr(6'd8, 0, 0);
        runInstr(6'd63, 0, 0);
        runInstr(6'd2, 0, 0);
        runInstr(6'd43, 2, 2);
        for (int n = 0; n < 40; n++) runInstr(pickOp(), $urandom_range(3), $urandom_range(3));
        memWait(6'd35, S_FETCH, 0, ok);
        e = '0; e.aluSrcB = 2'b11;
        cyc(6'd35, 1'b0, e, S_DECODE);
        e = '0; e.aluSrcA = 1; e.aluSrcB = 2'b10;
        cyc(6'd35, 1'b0, e, S_MADDR);
        e = '0; e.memRead = 1; e.iorD = 1;
        cyc(6'd35, 1'b0, e, S_RD);
        rstA = 1;
        expCount = 0;
        cyc(6'd35, 1'b0, '0, S_FETCH);
        cyc(6'd35, 1'b1, '0, S_FETCH);
        rstA = 0;
        runInstr(6'd0, 1, 0);
        runInstr(6'd35, 0, 0);
        rstA = 1;
        rstB = 0;
        sel = 1;
        expCount = 0;
        hasJump = 0;
        memTimeout = 4;
        runInstr(6'd0, 4, 0);
        runInstr(6'd2, 0, 0);
        runInstr(6'd35, 0, 4);
        runInstr(6'd43, 0, 4);
        runInstr(6'd43, 3, 3);
        runInstr(6'd35, 0, 3);
        for (int n = 0; n < 40; n++) runInstr(pickOp(), $urandom_range(6), $urandom_range(6));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
